knight_anim: RTL and testbench

KNIGHT_ANIM -- requirements
Module: knight_anim

---
 rtl/knight_anim.sv | 134 +++++++++++++
 tb/tb_knight_anim.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/knight_anim.sv
// Knight sprite animation sequencer: selects the animation from player status, steps
// frames every HOLD clocks, and runs a non-interruptible one-shot attack.
module knight_anim #(
   parameter int unsigned HOLD          = 4,
   parameter int unsigned ATTACK_FRAMES = 5
) (
   input  logic       frame_clk,
   input  logic       Reset_n,
   input  logic [3:0] Player_Status,
   input  logic       Inverse,
   output logic [2:0] anim_state,
   output logic [2:0] frame_idx,
   output logic [4:0] sprite_sel,
   output logic       facing_left,
   output logic       attack_busy,
   output logic       hit_window
);

   localparam int unsigned     HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
   localparam logic [2:0]      ATK_LAST  = 3'(ATTACK_FRAMES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WALK   = 3'd1,
      ST_JUMP   = 3'd2,
      ST_FALL   = 3'd3,
      ST_ATTACK = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      frame_q, frame_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            facing_q, facing_d;
   logic            atk_prev_q, atk_prev_d;
   logic            armed_q, armed_d;

   logic            status_is_atk;
   logic            atk_edge;
   logic            hold_wrap;
   logic            frame_last;
   logic            looping;
   state_e          target;
   logic [2:0]      last_frame;
   logic [4:0]      base;

   always_comb begin
      status_is_atk = (Player_Status == 4'd4);
      case (Player_Status)
         4'd1:    target = ST_WALK;
         4'd2:    target = ST_JUMP;
         4'd3:    target = ST_FALL;
         default: target = ST_IDLE;
      endcase
      // armed_q blocks an edge until a non-attack status has been sampled since reset
      atk_edge = status_is_atk & ~atk_prev_q & armed_q;
   end

   always_comb begin
      case (state_q)
         ST_IDLE:   begin last_frame = 3'd3;    looping = 1'b1; base = 5'd0;  end
         ST_WALK:   begin last_frame = 3'd5;    looping = 1'b1; base = 5'd4;  end
         ST_JUMP:   begin last_frame = 3'd1;    looping = 1'b0; base = 5'd10; end
         ST_FALL:   begin last_frame = 3'd1;    looping = 1'b0; base = 5'd12; end
         ST_ATTACK: begin last_frame = ATK_LAST; looping = 1'b0; base = 5'd14; end
         default:   begin last_frame = 3'd0;    looping = 1'b0; base = 5'd0;  end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      hold_d     = hold_q;
      facing_d   = (state_q == ST_ATTACK) ? facing_q : Inverse;
      atk_prev_d = status_is_atk;
      armed_d    = armed_q | ~status_is_atk;
      hold_wrap  = (hold_q == HOLD_LAST);
      frame_last = (frame_q == last_frame);

      if (hold_wrap) begin
         hold_d = '0;
         if (!frame_last)
            frame_d = frame_q + 3'd1;
         else if (looping)
            frame_d = '0;
      end else begin
         hold_d = hold_q + 1'b1;
      end

      if (state_q == ST_ATTACK) begin
         if (hold_wrap && frame_last) begin
            state_d = target;
            frame_d = '0;
            hold_d  = '0;
         end
      end else if (atk_edge) begin
         state_d = ST_ATTACK;
         frame_d = '0;
         hold_d  = '0;
      end else if (target != state_q) begin
         state_d = target;
         frame_d = '0;
         hold_d  = '0;
      end
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= ST_IDLE;
         frame_q    <= '0;
         hold_q     <= '0;
         facing_q   <= 1'b0;
         atk_prev_q <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         hold_q     <= hold_d;
         facing_q   <= facing_d;
         atk_prev_q <= atk_prev_d;
         armed_q    <= armed_d;
      end
   end

   always_comb begin
      anim_state  = state_q;
      frame_idx   = frame_q;
      sprite_sel  = base + {2'b00, frame_q};
      facing_left = facing_q;
      attack_busy = (state_q == ST_ATTACK);
      hit_window  = (state_q == ST_ATTACK) && ((frame_q == 3'd2) || (frame_q == 3'd3));
   end

endmodule

// File: tb/tb_knight_anim.sv
// Scoreboard bench for knight_anim: stimulus pushes per-cycle expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_knight_anim;

   logic       frame_clk = 1'b0;
   logic       Reset_n;
   logic [3:0] Player_Status;
   logic       Inverse;
   logic [2:0] anim_state;
   logic [2:0] frame_idx;
   logic [4:0] sprite_sel;
   logic       facing_left;
   logic       attack_busy;
   logic       hit_window;

   knight_anim #(.HOLD(4), .ATTACK_FRAMES(5)) dut (
      .frame_clk    (frame_clk),
      .Reset_n      (Reset_n),
      .Player_Status(Player_Status),
      .Inverse      (Inverse),
      .anim_state   (anim_state),
      .frame_idx    (frame_idx),
      .sprite_sel   (sprite_sel),
      .facing_left  (facing_left),
      .attack_busy  (attack_busy),
      .hit_window   (hit_window)
   );

   always #5 frame_clk = ~frame_clk;

   int unsigned cyc = 0;
   always @(posedge frame_clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [2:0]  st;
      logic [2:0]  fr;
      logic [4:0]  sp;
      logic        fl;
      logic        busy;
      logic        hit;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] ps, input logic inv);
      Player_Status = ps;
      Inverse       = inv;
   endtask

   task automatic expect_o(input string nm, input int st, input int fr, input int sp, input bit fl);
      exp_t e;
      e.cyc  = cyc;
      e.name = nm;
      e.st   = 3'(st);
      e.fr   = 3'(fr);
      e.sp   = 5'(sp);
      e.fl   = fl;
      e.busy = (st == 4);
      e.hit  = (st == 4) && (fr == 2 || fr == 3);
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge frame_clk);
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_chk++;
            if (e.cyc != cyc)
               $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d", e.name, e.cyc, cyc);
            else if ({anim_state, frame_idx, sprite_sel, facing_left, attack_busy, hit_window} !==
                     {e.st, e.fr, e.sp, e.fl, e.busy, e.hit})
               $display("FAIL %s @cyc %0d: got st=%0d fr=%0d sp=%0d fl=%0b busy=%0b hit=%0b, want st=%0d fr=%0d sp=%0d fl=%0b busy=%0b hit=%0b",
                        e.name, cyc, anim_state, frame_idx, sprite_sel, facing_left, attack_busy, hit_window,
                        e.st, e.fr, e.sp, e.fl, e.busy, e.hit);
            else
               n_pass++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int f;
      Reset_n = 1'b0;
      drive(4'd0, 1'b0);
      tick();
      expect_o("reset", 0, 0, 0, 0);
      tick();
      expect_o("reset2", 0, 0, 0, 0);
      Reset_n = 1'b1;

      // idle loop: frame steps every 4 cycles, wraps after frame 3
      for (int k = 1; k <= 40; k++) begin
         tick();
         f = (k / 4) % 4;
         expect_o("idle_loop", 0, f, f, 0);
      end

      // walk: one-cycle latency, sprite 4..9 and wrap
      drive(4'd1, 1'b1);
      for (int j = 0; j <= 26; j++) begin
         tick();
         f = (j / 4) % 6;
         expect_o("walk", 1, f, 4 + f, 1);
      end

      // jump clamps at frame 1
      drive(4'd2, 1'b1);
      for (int j = 0; j <= 19; j++) begin
         tick();
         f = (j >= 4) ? 1 : 0;
         expect_o("jump", 2, f, 10 + f, 1);
      end

      drive(4'd3, 1'b0);
      for (int j = 0; j <= 5; j++) begin
         tick();
         f = (j >= 4) ? 1 : 0;
         expect_o("fall", 3, f, 12 + f, 0);
      end

      drive(4'd9, 1'b0);
      for (int j = 0; j <= 2; j++) begin
         tick();
         expect_o("status9_idle", 0, 0, 0, 0);
      end

      // one-cycle attack pulse then walk; Inverse toggled during attack
      drive(4'd4, 1'b0);
      tick();
      expect_o("atk_start", 4, 0, 14, 0);
      drive(4'd1, 1'b1);
      for (int j = 1; j <= 19; j++) begin
         tick();
         expect_o("atk_pulse", 4, j / 4, 14 + j / 4, 0);
      end
      tick();
      expect_o("atk_to_walk", 1, 0, 4, 0);
      tick();
      expect_o("walk_face_after_atk", 1, 0, 4, 1);

      // status held at 4 with a 0-4 re-pulse at attack cycle 10
      drive(4'd0, 1'b0);
      tick();
      expect_o("idle_pre_hold", 0, 0, 0, 0);
      for (int j = 0; j <= 59; j++) begin
         if (j == 9) drive(4'd0, 1'b0);
         else        drive(4'd4, 1'b0);
         tick();
         if (j < 20) begin
            expect_o("atk_held", 4, j / 4, 14 + j / 4, 0);
         end else begin
            f = ((j - 20) / 4) % 4;
            expect_o("idle_after_held", 0, f, f, 0);
         end
      end

      // reset asserted at attack cycle 7
      drive(4'd0, 1'b1);
      tick();
      expect_o("idle_pre_rst", 0, 2, 2, 1);
      drive(4'd4, 1'b1);
      tick();
      expect_o("atk_rst_start", 4, 0, 14, 1);
      for (int j = 1; j <= 5; j++) begin
         tick();
         expect_o("atk_rst", 4, j / 4, 14 + j / 4, 1);
      end
      tick();
      #1;
      Reset_n = 1'b0;
      expect_o("async_rst", 0, 0, 0, 0);
      tick();
      expect_o("rst_hold", 0, 0, 0, 0);
      drive(4'd4, 1'b0);
      Reset_n = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         f = (k / 4) % 4;
         expect_o("no_atk_after_rst", 0, f, f, 0);
      end

      tick();
      #10;
      while (exp_q.size() > 0) begin
         n_chk++;
         $display("FAIL %s: expectation for cycle %0d never compared", exp_q[0].name, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
